// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the binary clock.
// Debounces the mode/inc buttons, sequences RUN -> SET_H -> SET_M -> COMMIT,
// freezes the time counters while editing, emits a one-cycle load strobe with
// the edited values, and drives a blink mask for the field being edited.

// Two-flop synchronizer followed by a stability counter; level follows the
// synchronized input only after it has differed for DEBOUNCE_CYCLES samples.
module clock_set_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: shift the synchronizer and count samples that disagree.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = {CW{1'b0}};
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int BLINK_BITS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       hold,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [1:0] blank_mask,
  output logic [1:0] mode
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_SET_H  = 2'd1;
  localparam logic [1:0] ST_SET_M  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int IW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] REP_HOLD = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_INT  = RW'(REPEAT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  logic mode_lvl, inc_lvl;
  logic mode_evt, inc_press, rep_fire, inc_evt;

  logic                  mode_prev_q, mode_prev_d;
  logic                  inc_prev_q, inc_prev_d;
  logic [RW-1:0]         rep_cnt_q, rep_cnt_d;
  logic                  rep_on_q, rep_on_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [1:0]            mode_q, mode_d;
  logic [4:0]            edit_h_q, edit_h_d;
  logic [5:0]            edit_m_q, edit_m_d;
  logic                  hold_q, hold_d;
  logic                  load_q, load_d;
  logic [4:0]            load_hours_q, load_hours_d;
  logic [5:0]            load_minutes_q, load_minutes_d;
  logic [1:0]            blank_mask_q, blank_mask_d;

  clock_set_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .level (mode_lvl)
  );

  clock_set_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_inc),
    .level (inc_lvl)
  );

  // Press edges and inc auto-repeat: first repeat after HOLD_CYCLES of
  // continuous high, then every REPEAT_CYCLES; release clears it at once.
  always_comb begin
    mode_prev_d = mode_lvl;
    inc_prev_d  = inc_lvl;
    mode_evt    = mode_lvl & ~mode_prev_q;
    inc_press   = inc_lvl & ~inc_prev_q;
    rep_fire    = 1'b0;
    rep_cnt_d   = {RW{1'b0}};
    rep_on_d    = 1'b0;
    if (inc_lvl) begin
      if (!rep_on_q && (rep_cnt_q == REP_HOLD)) begin
        rep_fire  = 1'b1;
        rep_on_d  = 1'b1;
        rep_cnt_d = RW'(1);
      end else if (rep_on_q && (rep_cnt_q == REP_INT)) begin
        rep_fire  = 1'b1;
        rep_on_d  = 1'b1;
        rep_cnt_d = RW'(1);
      end else begin
        rep_on_d  = rep_on_q;
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end else begin
      rep_on_d  = 1'b0;
      rep_cnt_d = {RW{1'b0}};
    end
    inc_evt = inc_press | rep_fire;
  end

  // Edit sequencer; mode beats inc in the same cycle, idle timeout aborts
  // without loading. Outputs are derived from next-state so they register
  // in step with mode.
  always_comb begin
    mode_d   = mode_q;
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    idle_d   = {IW{1'b0}};
    blink_d  = inc_evt ? {BLINK_BITS{1'b0}} : (blink_q + BLINK_BITS'(1));
    case (mode_q)
      ST_RUN: begin
        if (mode_evt) begin
          mode_d   = ST_SET_H;
          edit_h_d = (cur_hours < 5'd24) ? cur_hours : 5'd0;
          edit_m_d = (cur_minutes < 6'd60) ? cur_minutes : 6'd0;
        end else begin
          mode_d = ST_RUN;
        end
      end
      ST_SET_H: begin
        if (mode_evt) begin
          mode_d = ST_SET_M;
        end else if (inc_evt) begin
          edit_h_d = (edit_h_q == 5'd23) ? 5'd0 : (edit_h_q + 5'd1);
        end else if (idle_q == IDLE_LAST) begin
          mode_d = ST_RUN;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      ST_SET_M: begin
        if (mode_evt) begin
          mode_d = ST_COMMIT;
        end else if (inc_evt) begin
          edit_m_d = (edit_m_q == 6'd59) ? 6'd0 : (edit_m_q + 6'd1);
        end else if (idle_q == IDLE_LAST) begin
          mode_d = ST_RUN;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      ST_COMMIT: begin
        mode_d = ST_RUN;
      end
      default: begin
        mode_d = ST_RUN;
      end
    endcase
    hold_d         = (mode_d != ST_RUN);
    load_d         = (mode_d == ST_COMMIT);
    load_hours_d   = load_d ? edit_h_d : load_hours_q;
    load_minutes_d = load_d ? edit_m_d : load_minutes_q;
    blank_mask_d   = {(mode_d == ST_SET_H) & blink_d[BLINK_BITS-1],
                      (mode_d == ST_SET_M) & blink_d[BLINK_BITS-1]};
  end

  // Controller state and registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_prev_q    <= 1'b0;
      inc_prev_q     <= 1'b0;
      rep_cnt_q      <= {RW{1'b0}};
      rep_on_q       <= 1'b0;
      idle_q         <= {IW{1'b0}};
      blink_q        <= {BLINK_BITS{1'b0}};
      mode_q         <= ST_RUN;
      edit_h_q       <= 5'd0;
      edit_m_q       <= 6'd0;
      hold_q         <= 1'b0;
      load_q         <= 1'b0;
      load_hours_q   <= 5'd0;
      load_minutes_q <= 6'd0;
      blank_mask_q   <= 2'b00;
    end else begin
      mode_prev_q    <= mode_prev_d;
      inc_prev_q     <= inc_prev_d;
      rep_cnt_q      <= rep_cnt_d;
      rep_on_q       <= rep_on_d;
      idle_q         <= idle_d;
      blink_q        <= blink_d;
      mode_q         <= mode_d;
      edit_h_q       <= edit_h_d;
      edit_m_q       <= edit_m_d;
      hold_q         <= hold_d;
      load_q         <= load_d;
      load_hours_q   <= load_hours_d;
      load_minutes_q <= load_minutes_d;
      blank_mask_q   <= blank_mask_d;
    end
  end

  assign hold         = hold_q;
  assign load         = load_q;
  assign load_hours   = load_hours_q;
  assign load_minutes = load_minutes_q;
  assign blank_mask   = blank_mask_q;
  assign mode         = mode_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: expected load values go into a
// scoreboard queue, a negedge monitor compares every load pulse.
module tb_clock_set_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       hold;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [1:0] blank_mask;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;
  logic        post_load = 1'b0;

  clock_set_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_hours    (cur_hours),
    .cur_minutes  (cur_minutes),
    .hold         (hold),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .blank_mask   (blank_mask),
    .mode         (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Raw press held for n cycles, then released long enough to debounce low.
  task automatic press(input logic m, input logic i, input int n);
    btn_mode = m;
    btn_inc  = i;
    repeat (n) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Monitor: every load pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst) begin
      if (post_load) begin
        check("after_load_mode", mode, 0);
        check("after_load_hold", hold, 0);
      end
      post_load = load;
      if (load) begin
        check("load_mode", mode, 3);
        check("load_hold", hold, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_load: got h=%0d m=%0d expected no load", load_hours, load_minutes);
        end else begin
          mon_exp = exp_q.pop_front();
          check("load_hours", load_hours, mon_exp[10:6]);
          check("load_minutes", load_minutes, mon_exp[5:0]);
        end
      end
    end else begin
      post_load = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_t;
    int trans;
    logic prev_b;
    logic bm0_bad;

    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hours = 5'd0; cur_minutes = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_hold", hold, 0);
    check("rst_load", load, 0);
    check("rst_lh", load_hours, 0);
    check("rst_lm", load_minutes, 0);
    check("rst_blank", blank_mask, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Debounce: 3-cycle glitch ignored, held press gives SET_H at clock 7.
    cur_hours = 5'd10; cur_minutes = 6'd5;
    btn_mode = 1'b1;
    repeat (3) @(negedge clk);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_mode", mode, 0);
    btn_mode = 1'b1;
    repeat (6) @(negedge clk);
    check("lat_early_mode", mode, 0);
    @(negedge clk);
    check("lat_mode", mode, 1);
    check("lat_hold", hold, 1);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);

    // Full set: 10:05 -> +3h, +2m -> 13:07.
    repeat (3) press(1'b1 ? 1'b0 : 1'b0, 1'b1, 8);
    check("seth_mode", mode, 1);
    press(1'b1, 1'b0, 8);
    check("setm_mode", mode, 2);
    check("setm_hold", hold, 1);
    repeat (2) press(1'b0, 1'b1, 8);
    exp_q.push_back({5'd13, 6'd7});
    press(1'b1, 1'b0, 8);
    check("full_run_mode", mode, 0);
    check("full_run_hold", hold, 0);

    // Wrap 23:59 -> 00:00.
    cur_hours = 5'd23; cur_minutes = 6'd59;
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    exp_q.push_back({5'd0, 6'd0});
    press(1'b1, 1'b0, 8);

    // Out-of-range capture then auto-repeat: press + 4 repeats = 5.
    cur_hours = 5'd30; cur_minutes = 6'd45;
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 31);
    press(1'b1, 1'b0, 8);
    exp_q.push_back({5'd5, 6'd45});
    press(1'b1, 1'b0, 8);

    // Blink in SET_H: hours mask toggles every 8 cycles, minutes mask idle.
    cur_hours = 5'd12; cur_minutes = 6'd34;
    press(1'b1, 1'b0, 8);
    last_t = -1; trans = 0; bm0_bad = 1'b0; prev_b = blank_mask[1];
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (blank_mask[0]) bm0_bad = 1'b1;
      if (blank_mask[1] != prev_b) begin
        if (last_t >= 0) check("blink_period", c - last_t, 8);
        last_t = c;
        trans++;
        prev_b = blank_mask[1];
      end
    end
    check("blink_toggles", (trans >= 4) ? 1 : 0, 1);
    check("blink_bm0", bm0_bad, 0);

    // Simultaneous mode+inc: advance, hours unchanged.
    press(1'b1, 1'b1, 8);
    check("simul_mode", mode, 2);
    exp_q.push_back({5'd12, 6'd34});
    press(1'b1, 1'b0, 8);

    // Timeout in SET_M: abort to RUN, no load.
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    repeat (1000) @(negedge clk);
    check("pre_timeout_mode", mode, 2);
    repeat (30) @(negedge clk);
    check("timeout_mode", mode, 0);
    check("timeout_hold", hold, 0);

    // Asynchronous reset mid SET_H clears every output immediately.
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    check("pre_rst_mode", mode, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_mode", mode, 0);
    check("arst_hold", hold, 0);
    check("arst_load", load, 0);
    check("arst_lh", load_hours, 0);
    check("arst_lm", load_minutes, 0);
    check("arst_blank", blank_mask, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_mode", mode, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
